// File: rtl/qam_symbol_packer_if.sv
// Byte-in / symbol-out bundle between the byte source, the packer and the QAM mapper.
// slave is the packer's view of the bundle; master is the source/mapper side.
interface qam_symbol_packer_if;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       last_i;
  logic       byte_ready_o;
  logic [3:0] symbol_o;
  logic       data_valid_o;
  logic       start_o;
  logic       done_flag_o;
  logic       busy_o;

  modport slave (
    input  byte_i, byte_valid_i, last_i,
    output byte_ready_o, symbol_o, data_valid_o, start_o, done_flag_o, busy_o
  );

  modport master (
    output byte_i, byte_valid_i, last_i,
    input  byte_ready_o, symbol_o, data_valid_o, start_o, done_flag_o, busy_o
  );
endinterface

// File: rtl/qam_symbol_packer.sv
// Byte FIFO feeding a nibble splitter that paces 4-bit symbols to the 16-QAM mapper,
// framing each burst with start_o and done_flag_o.
//
// state   | meaning
// IDLE    | no frame, waiting for a byte in the FIFO
// START   | one-cycle start_o pulse to the mapper
// HI      | high nibble slot of the held byte
// LO      | low nibble slot; done_flag_o if the held byte ends the frame
// WAIT    | underrun inside a frame, waiting for the next byte
// DONE    | one-cycle frame tail before IDLE
module qam_symbol_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SYM_PERIOD = 2
) (
  input logic           clk,
  input logic           rst,
  qam_symbol_packer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HI, S_LO, S_WAIT, S_DONE
  } state_t;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          pop;
  logic [8:0]    head;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [8:0]    hold_q;
  logic [3:0]    sym_q;
  logic          dv_q;
  logic          start_q;
  logic          done_q;
  logic          busy_q;
  logic          slot_end;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en = bus.byte_valid_i && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign bus.byte_ready_o = !full;
  assign bus.symbol_o     = sym_q;
  assign bus.data_valid_o = dv_q;
  assign bus.start_o      = start_q;
  assign bus.done_flag_o  = done_q;
  assign bus.busy_o       = busy_q;

  assign slot_end = (cnt_q == CW'(SYM_PERIOD - 1));

  // Every entry to HI consumes the FIFO head into the holding register.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_START: pop = 1'b1;
      S_LO:    pop = slot_end && !hold_q[8] && !empty;
      S_WAIT:  pop = !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.last_i, bus.byte_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      sym_q   <= '0;
      dv_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            state_q <= S_START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          state_q <= S_HI;
          hold_q  <= head;
          sym_q   <= head[7:4];
          dv_q    <= 1'b1;
        end
        S_HI: begin
          if (slot_end) begin
            state_q <= S_LO;
            sym_q   <= hold_q[3:0];
            dv_q    <= 1'b1;
            done_q  <= hold_q[8];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_LO: begin
          if (!slot_end) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (hold_q[8]) begin
            state_q <= S_DONE;
            sym_q   <= '0;
          end else if (!empty) begin
            state_q <= S_HI;
            hold_q  <= head;
            sym_q   <= head[7:4];
            dv_q    <= 1'b1;
          end else begin
            state_q <= S_WAIT;
            sym_q   <= '0;
          end
        end
        S_WAIT: begin
          if (!empty) begin
            state_q <= S_HI;
            hold_q  <= head;
            sym_q   <= head[7:4];
            dv_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          sym_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qam_symbol_packer.sv
// Scoreboard bench: accepted bytes become expected (symbol, done) pairs in a queue,
// per-DUT monitors pop and compare on every data_valid_o strobe.
module tb_qam_symbol_packer;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qam_symbol_packer_if bus1();
  qam_symbol_packer_if bus2();

  qam_symbol_packer #(.FIFO_DEPTH(4), .SYM_PERIOD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  qam_symbol_packer #(.FIFO_DEPTH(4), .SYM_PERIOD(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct packed {
    logic [3:0] sym;
    logic       done;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   dv_cyc1[$], start_cyc1[$], done_cyc1[$];
  int   dv_cyc2[$], start_cyc2[$], done_cyc2[$];
  bit   open1 = 1'b0;
  bit   open2 = 1'b0;

  // {start, dv, symbol, done, busy} per cycle for a lone 0xA5 frame, SYM_PERIOD=2
  logic [7:0] t1_exp [7] = '{8'b1_0_0000_0_1, 8'b0_1_1010_0_1, 8'b0_0_1010_0_1,
                             8'b0_1_0101_1_1, 8'b0_0_0101_0_1, 8'b0_0_0000_0_1,
                             8'b0_0_0000_0_0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] obs(input int which);
    if (which == 1)
      return {bus1.start_o, bus1.data_valid_o, bus1.symbol_o, bus1.done_flag_o, bus1.busy_o};
    return {bus2.start_o, bus2.data_valid_o, bus2.symbol_o, bus2.done_flag_o, bus2.busy_o};
  endfunction

  function automatic logic ready(input int which);
    return (which == 1) ? bus1.byte_ready_o : bus2.byte_ready_o;
  endfunction

  // Reference: every byte yields its high nibble then its low nibble; done rides on the low nibble of a last byte.
  function automatic void model_byte(input int which, input logic [7:0] b, input logic last);
    exp_t hi;
    exp_t lo;
    hi.sym = b[7:4];
    hi.done = 1'b0;
    lo.sym = b[3:0];
    lo.done = last;
    if (which == 1) begin
      q1.push_back(hi);
      q1.push_back(lo);
    end else begin
      q2.push_back(hi);
      q2.push_back(lo);
    end
  endfunction

  task automatic drive(input int which, input logic [7:0] b, input logic last, input logic v);
    if (which == 1) begin
      bus1.byte_i = b; bus1.last_i = last; bus1.byte_valid_i = v;
    end else begin
      bus2.byte_i = b; bus2.last_i = last; bus2.byte_valid_i = v;
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte is accepted.
  task automatic send(input int which, input logic [7:0] b, input logic last);
    bit ok = 1'b0;
    drive(which, b, last, 1'b1);
    for (int n = 0; n < 100 && !ok; n++) begin
      if (ready(which)) begin
        @(posedge clk);
        model_byte(which, b, last);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    drive(which, 8'h00, 1'b0, 1'b0);
    if (!ok) check("send_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int which);
    bit ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (which == 1)
        ok = !bus1.busy_o && (q1.size() == 0) && bus1.byte_ready_o;
      else
        ok = !bus2.busy_o && (q2.size() == 0) && bus2.byte_ready_o;
      if (!ok) @(negedge clk);
    end
    if (!ok) check("wait_idle_timeout", which, 0);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      if (bus1.start_o) begin
        check("p1_start_outside_frame", int'(open1), 0);
        open1 = 1'b1;
        start_cyc1.push_back(cyc);
      end
      if (bus1.data_valid_o) begin
        dv_cyc1.push_back(cyc);
        check("p1_strobe_in_frame", int'(open1), 1);
        check("p1_sb_nonempty", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("p1_symbol", bus1.symbol_o, e.sym);
          check("p1_done_flag", bus1.done_flag_o, e.done);
        end
        if (bus1.done_flag_o) begin
          open1 = 1'b0;
          done_cyc1.push_back(cyc);
        end
      end else begin
        check("p1_done_without_strobe", bus1.done_flag_o, 0);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst) begin
      if (bus2.start_o) begin
        check("p2_start_outside_frame", int'(open2), 0);
        open2 = 1'b1;
        start_cyc2.push_back(cyc);
      end
      if (bus2.data_valid_o) begin
        dv_cyc2.push_back(cyc);
        check("p2_strobe_in_frame", int'(open2), 1);
        check("p2_sb_nonempty", int'(q2.size() > 0), 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          check("p2_symbol", bus2.symbol_o, e.sym);
          check("p2_done_flag", bus2.done_flag_o, e.done);
        end
        if (bus2.done_flag_o) begin
          open2 = 1'b0;
          done_cyc2.push_back(cyc);
        end
      end else begin
        check("p2_done_without_strobe", bus2.done_flag_o, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, nd, base, first_stall, nf, len;
    rst = 1'b0;
    drive(1, 8'h00, 1'b0, 1'b0);
    drive(2, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_outputs_p1", {obs(1), ready(1)}, 9'b0_0_0000_0_0_1);
    check("reset_outputs_p2", {obs(2), ready(2)}, 9'b0_0_0000_0_0_1);
    rst = 1'b1;
    @(negedge clk);

    // Lone single-byte frame: exact cycle-by-cycle latency and hold
    send(2, 8'hA5, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("t1_cycle%0d", k + 1), obs(2), t1_exp[k]);
    end
    wait_idle(2);

    // Back-to-back burst: contiguous strobes two cycles apart
    dv_cyc2.delete();
    ns = start_cyc2.size();
    nd = done_cyc2.size();
    send(2, 8'h12, 1'b0);
    send(2, 8'h34, 1'b0);
    send(2, 8'h56, 1'b1);
    wait_idle(2);
    check("t2_strobe_count", dv_cyc2.size(), 6);
    if (dv_cyc2.size() == 6) begin
      for (int i = 1; i < 6; i++) check("t2_strobe_spacing", dv_cyc2[i] - dv_cyc2[i-1], 2);
      if (done_cyc2.size() > nd) check("t2_done_on_last_symbol", done_cyc2[done_cyc2.size()-1], dv_cyc2[5]);
    end
    check("t2_start_count", start_cyc2.size() - ns, 1);
    check("t2_done_count", done_cyc2.size() - nd, 1);

    // Continuous valid: ready drops once the FIFO fills. From idle, one pop happens
    // (START->HI) before the FIFO fills, so the fifth write is the one that fills it.
    first_stall = -1;
    for (int i = 0; i < 10; i++) begin
      if (!bus2.byte_ready_o && first_stall < 0) first_stall = i;
      send(2, 8'($urandom), i == 9);
    end
    check("t3_writes_before_full", first_stall, 5);
    wait_idle(2);

    // Underrun: gap inside a frame goes through WAIT without a new start
    ns = start_cyc2.size();
    send(2, 8'h7E, 1'b0);
    repeat (10) @(negedge clk);
    check("t4_underrun_wait", obs(2), 8'b0_0_0000_0_1);
    send(2, 8'h01, 1'b1);
    wait_idle(2);
    check("t4_start_count", start_cyc2.size() - ns, 1);

    // Reset during LO of a three-byte frame, then a clean new frame
    base = dv_cyc2.size();
    send(2, 8'h3C, 1'b0);
    send(2, 8'h96, 1'b0);
    send(2, 8'h0F, 1'b1);
    for (int n = 0; n < 50 && dv_cyc2.size() < base + 2; n++) @(negedge clk);
    check("t5_reached_lo", int'(dv_cyc2.size() >= base + 2), 1);
    #1 rst = 1'b0;
    #1 check("t5_async_reset_outputs", {obs(2), ready(2)}, 9'b0_0_0000_0_0_1);
    q2.delete();
    open2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q1.delete();
    open1 = 1'b0;
    ns = start_cyc2.size();
    send(2, 8'hC3, 1'b1);
    wait_idle(2);
    check("t5_restart_start_count", start_cyc2.size() - ns, 1);

    // Random frames with random gaps between bytes
    ns = start_cyc2.size();
    nd = done_cyc2.size();
    nf = 20;
    for (int f = 0; f < nf; f++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        send(2, 8'($urandom), b == len - 1);
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    wait_idle(2);
    check("rand_start_count", start_cyc2.size() - ns, nf);
    check("rand_done_count", done_cyc2.size() - nd, nf);

    // SYM_PERIOD=1: two queued frames back-to-back
    send(1, 8'hAB, 1'b0);
    send(1, 8'hCD, 1'b1);
    send(1, 8'hEF, 1'b0);
    send(1, 8'h90, 1'b1);
    wait_idle(1);
    check("t6_strobe_count", dv_cyc1.size(), 8);
    if (dv_cyc1.size() == 8) begin
      for (int i = 1; i < 8; i++)
        check($sformatf("t6_spacing%0d", i), dv_cyc1[i] - dv_cyc1[i-1], (i == 4) ? 4 : 1);
    end
    check("t6_start_count", start_cyc1.size(), 2);
    check("t6_done_count", done_cyc1.size(), 2);
    if (start_cyc1.size() == 2 && done_cyc1.size() == 2)
      check("t6_interframe_gap", start_cyc1[1] - done_cyc1[0], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
